// File: rtl/bin_to_7segmentos_submodulo_if.sv
// Bundle of the value input and display pins for the 7-segment driver.
interface bin_to_7segmentos_submodulo_if;
  logic [3:0] in;
  logic       Digito_decena;
  logic       Digito_unidad;
  logic       Digito_centena;
  logic       Digito_milesima;
  logic [6:0] cSeg7;

  modport master (
    output in,
    input  Digito_decena, Digito_unidad, Digito_centena, Digito_milesima,
    input  cSeg7
  );

  modport slave (
    input  in,
    output Digito_decena, Digito_unidad, Digito_centena, Digito_milesima,
    output cSeg7
  );
endinterface

// File: rtl/bin_to_7segmentos_submodulo.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Shows a 4-bit value (0-15) in decimal on the units/tens digits; the
// hundreds and thousands digits stay blank. All outputs are registered.
module bin_to_7segmentos_submodulo #(
  parameter int SCAN_BITS = 18
) (
  input logic                          reloj,
  input logic                          reset,
  bin_to_7segmentos_submodulo_if.slave bus
);

  localparam logic [SCAN_BITS-1:0] CNT_ONE = 1;
  localparam logic [6:0]           SEG_BLANK = 7'h7F;

  logic [SCAN_BITS-1:0] cnt;
  logic [3:0]           in_q;
  logic [1:0]           slot;
  logic [3:0]           units;
  logic                 tens;
  logic [3:0]           digit_nxt;
  logic [6:0]           seg_nxt;
  // {milesima, centena, decena, unidad}, active-low
  logic [3:0]           digit_q;
  logic [6:0]           seg_q;

  // Segment pattern for one decimal digit; anything else is blank.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign slot = cnt[SCAN_BITS-1 -: 2];

  // Split the registered value into its units and tens digits.
  always_comb begin
    tens  = (in_q >= 4'd10);
    units = tens ? (in_q - 4'd10) : in_q;
  end

  // Pick the active digit and its content for the current slot.
  always_comb begin
    digit_nxt = 4'b1111;
    seg_nxt   = SEG_BLANK;
    case (slot)
      2'd0: begin
        digit_nxt = 4'b1110;
        seg_nxt   = seg_of(units);
      end
      2'd1: begin
        digit_nxt = 4'b1101;
        // leading zero suppressed: the tens digit is only lit for 10-15
        seg_nxt   = tens ? seg_of(4'd1) : SEG_BLANK;
      end
      2'd2: digit_nxt = 4'b1011;
      default: digit_nxt = 4'b0111;
    endcase
  end

  // Refresh counter, input capture and output registers.
  always_ff @(posedge reloj) begin
    if (reset) begin
      cnt     <= '0;
      in_q    <= 4'd0;
      digit_q <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt     <= cnt + CNT_ONE;
      in_q    <= bus.in;
      digit_q <= digit_nxt;
      seg_q   <= seg_nxt;
    end
  end

  assign bus.Digito_unidad   = digit_q[0];
  assign bus.Digito_decena   = digit_q[1];
  assign bus.Digito_centena  = digit_q[2];
  assign bus.Digito_milesima = digit_q[3];
  assign bus.cSeg7           = seg_q;

endmodule

// File: tb/tb_bin_to_7segmentos_submodulo.sv
// Directed bench for the 7-segment display driver.
// Main instance uses SCAN_BITS=4 (4-cycle slots); a second instance with
// SCAN_BITS=3 (2-cycle slots) lines up with the 100 ns value sequence.
module tb_bin_to_7segmentos_submodulo;

  logic reloj;
  logic reset;
  int   n_checks;
  int   n_fail;

  bin_to_7segmentos_submodulo_if bus4 ();
  bin_to_7segmentos_submodulo_if bus3 ();

  bin_to_7segmentos_submodulo #(.SCAN_BITS(4)) dut4 (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus4.slave)
  );

  bin_to_7segmentos_submodulo #(.SCAN_BITS(3)) dut3 (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus3.slave)
  );

  initial reloj = 1'b0;
  always #10 reloj = ~reloj;

  function automatic logic [3:0] en4();
    return {bus4.Digito_milesima, bus4.Digito_centena, bus4.Digito_decena, bus4.Digito_unidad};
  endfunction

  function automatic logic [3:0] en3();
    return {bus3.Digito_milesima, bus3.Digito_centena, bus3.Digito_decena, bus3.Digito_unidad};
  endfunction

  // one rising edge, then settle on the falling edge for sampling/driving
  task automatic tick();
    @(posedge reloj);
    @(negedge reloj);
  endtask

  task automatic apply_reset(input logic [3:0] v4, input logic [3:0] v3);
    bus4.in = v4;
    bus3.in = v3;
    reset   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus4.in = 4'd7;
    bus3.in = 4'd7;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (en4() !== 4'b1111) begin
        n_fail++;
        $display("FAIL reset_enables cycle %0d: got %b want 1111", i, en4());
      end
      n_checks++;
      if (bus4.cSeg7 !== 7'h7F) begin
        n_fail++;
        $display("FAIL reset_seg cycle %0d: got %h want 7f", i, bus4.cSeg7);
      end
    end
    n_checks++;
    if (en3() !== 4'b1111 || bus3.cSeg7 !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_dut3: got en %b seg %h want 1111 7f", en3(), bus3.cSeg7);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (en4() !== 4'b1110) begin
      n_fail++;
      $display("FAIL release_enables: got %b want 1110", en4());
    end
    n_checks++;
    if (bus4.cSeg7 !== 7'h40) begin
      n_fail++;
      $display("FAIL release_seg: got %h want 40", bus4.cSeg7);
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    int         s;
    apply_reset(4'd1, 4'd0);
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k >= 2) begin
        s       = ((k - 1) >> 2) & 3;
        exp_en  = 4'b1111 ^ (4'b0001 << s);
        exp_seg = (s == 0) ? 7'h79 : 7'h7F;
        n_checks++;
        if (en4() !== exp_en) begin
          n_fail++;
          $display("FAIL scan_enables k=%0d: got %b want %b", k, en4(), exp_en);
        end
        n_checks++;
        if ($countones(~en4()) != 1) begin
          n_fail++;
          $display("FAIL scan_onehot k=%0d: got %b want exactly one low", k, en4());
        end
        n_checks++;
        if (bus4.cSeg7 !== exp_seg) begin
          n_fail++;
          $display("FAIL scan_seg k=%0d: got %h want %h", k, bus4.cSeg7, exp_seg);
        end
      end
    end
  endtask

  task automatic test_two_digit();
    logic [3:0] vals[2];
    logic [6:0] exp_u[2];
    vals[0] = 4'd12; exp_u[0] = 7'h24;
    vals[1] = 4'd15; exp_u[1] = 7'h12;
    for (int v = 0; v < 2; v++) begin
      apply_reset(vals[v], 4'd0);
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (k == 3) begin
          n_checks++;
          if (en4() !== 4'b1110 || bus4.cSeg7 !== exp_u[v]) begin
            n_fail++;
            $display("FAIL two_digit_units in=%0d: got en %b seg %h want 1110 %h",
                     vals[v], en4(), bus4.cSeg7, exp_u[v]);
          end
        end
        if (k == 6) begin
          n_checks++;
          if (en4() !== 4'b1101 || bus4.cSeg7 !== 7'h79) begin
            n_fail++;
            $display("FAIL two_digit_tens in=%0d: got en %b seg %h want 1101 79",
                     vals[v], en4(), bus4.cSeg7);
          end
        end
      end
    end
  endtask

  task automatic test_sequence();
    logic [6:0] exp_seg;
    apply_reset(4'd0, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      if (k >= 4 && k <= 8)       bus3.in = 4'd1;
      else if (k >= 9 && k <= 13) bus3.in = 4'd2;
      else if (k >= 14)           bus3.in = 4'd3;
      else                        bus3.in = 4'd0;
      tick();
      case (k)
        1, 2:    exp_seg = 7'h40;
        9:       exp_seg = 7'h79;
        10:      exp_seg = 7'h24;
        17, 18:  exp_seg = 7'h30;
        default: exp_seg = 7'h7F;
      endcase
      n_checks++;
      if (bus3.cSeg7 !== exp_seg) begin
        n_fail++;
        $display("FAIL sequence_seg k=%0d: got %h want %h", k, bus3.cSeg7, exp_seg);
      end
    end
  endtask

  task automatic test_latency();
    apply_reset(4'd0, 4'd0);
    tick();
    n_checks++;
    if (bus4.cSeg7 !== 7'h40) begin
      n_fail++;
      $display("FAIL latency_before: got %h want 40", bus4.cSeg7);
    end
    bus4.in = 4'd8;
    tick();
    n_checks++;
    if (bus4.cSeg7 !== 7'h40) begin
      n_fail++;
      $display("FAIL latency_one_cycle: got %h want 40", bus4.cSeg7);
    end
    tick();
    n_checks++;
    if (bus4.cSeg7 !== 7'h00 || en4() !== 4'b1110) begin
      n_fail++;
      $display("FAIL latency_two_cycles: got seg %h en %b want 00 1110", bus4.cSeg7, en4());
    end
  endtask

  task automatic test_midscan_reset();
    apply_reset(4'd5, 4'd0);
    repeat (10) tick();
    n_checks++;
    if (en4() !== 4'b1011 || bus4.cSeg7 !== 7'h7F) begin
      n_fail++;
      $display("FAIL midscan_centena: got en %b seg %h want 1011 7f", en4(), bus4.cSeg7);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (en4() !== 4'b1111 || bus4.cSeg7 !== 7'h7F) begin
      n_fail++;
      $display("FAIL midscan_off: got en %b seg %h want 1111 7f", en4(), bus4.cSeg7);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (en4() !== 4'b1110 || bus4.cSeg7 !== 7'h40) begin
      n_fail++;
      $display("FAIL midscan_restart: got en %b seg %h want 1110 40", en4(), bus4.cSeg7);
    end
    tick();
    n_checks++;
    if (en4() !== 4'b1110 || bus4.cSeg7 !== 7'h12) begin
      n_fail++;
      $display("FAIL midscan_value: got en %b seg %h want 1110 12", en4(), bus4.cSeg7);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus4.in  = 4'd0;
    bus3.in  = 4'd0;
    @(negedge reloj);
    test_reset();
    test_scan_order();
    test_two_digit();
    test_sequence();
    test_latency();
    test_midscan_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
